// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: opcode map,
// registered-decision encoding and the shadow-stage record.
package pipeline_pkg;

  // Widest register index the shadow record can hold; narrower RW values
  // are zero-extended into it.
  localparam int unsigned REG_IDX_W = 16;

  localparam logic [3:0] ALUR   = 4'h0;
  localparam logic [3:0] ALUI   = 4'h1;
  localparam logic [3:0] BRANCH = 4'h2;
  localparam logic [3:0] SWOP   = 4'h3;
  localparam logic [3:0] LWOP   = 4'h4;
  localparam logic [3:0] CMPR   = 4'h5;
  localparam logic [3:0] CMPI   = 4'h6;
  localparam logic [3:0] JAL    = 4'h7;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'b00,
    HZ_STALL = 2'b01,
    HZ_FLUSH = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [REG_IDX_W-1:0] rd;
  } shadow_entry_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_shadow_stage.sv
// One shadow pipeline slot tracking {valid, wr, rd} of the instruction
// occupying a downstream stage.
module hazard_shadow_stage
  import pipeline_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          bubble,
  input  shadow_entry_t src,
  output shadow_entry_t entry
);

  // Bubble wins over load so a squashed/stalled slot never carries a writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry <= '0;
    end else if (bubble) begin
      entry <= '0;
    end else if (load) begin
      entry <= src;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline without forwarding:
// stalls DEC on a RAW dependence against EX/ME/WB, flushes on a taken
// branch, and keeps saturating stall/flush statistics.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned OPW  = 4,
  parameter int unsigned RW   = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  dec_op,
  input  logic [RW-1:0]   dec_rs1,
  input  logic [RW-1:0]   dec_rs2,
  input  logic [RW-1:0]   dec_rd,
  input  logic            ex_br_taken,
  output logic            pc_we,
  output logic            ifdec_we,
  output logic            ifdec_flush,
  output logic            decex_bubble,
  output logic            ex_valid,
  output logic            me_valid,
  output logic            wb_valid,
  output logic [1:0]      hz_state,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  hz_state_t     hz_q, hz_d;
  shadow_entry_t dec_e, ex_e, me_e, wb_e;
  logic          dec_valid, dec_wr, use_rs1, use_rs2, hazard;

  // r0 is hardwired, so it never creates a dependence.
  function automatic logic src_hit(input logic [RW-1:0] src, input shadow_entry_t e);
    return (src != '0) && e.valid && e.wr && (e.rd == REG_IDX_W'(src));
  endfunction

  // Decode of the DEC instruction and RAW hazard detection against EX/ME/WB.
  always_comb begin
    dec_valid = (hz_q != HZ_FLUSH);
    dec_wr    = (dec_op != OPW'(SWOP)) && (dec_op != OPW'(BRANCH));
    use_rs1   = dec_op inside {OPW'(ALUR), OPW'(ALUI), OPW'(LWOP), OPW'(SWOP),
                               OPW'(CMPR), OPW'(CMPI), OPW'(BRANCH), OPW'(JAL)};
    use_rs2   = dec_op inside {OPW'(ALUR), OPW'(CMPR), OPW'(SWOP), OPW'(BRANCH)};
    dec_e       = '0;
    dec_e.valid = dec_valid;
    dec_e.wr    = dec_wr;
    dec_e.rd    = REG_IDX_W'(dec_rd);
    hazard = dec_valid &&
             ((use_rs1 && (src_hit(dec_rs1, ex_e) || src_hit(dec_rs1, me_e) ||
                           src_hit(dec_rs1, wb_e))) ||
              (use_rs2 && (src_hit(dec_rs2, ex_e) || src_hit(dec_rs2, me_e) ||
                           src_hit(dec_rs2, wb_e))));
  end

  // Per-cycle decision (FLUSH > STALL > RUN) and the control outputs it drives;
  // reset forces RUN so no squash or stall is visible while it is held.
  always_comb begin
    hz_d         = HZ_RUN;
    pc_we        = 1'b1;
    ifdec_we     = 1'b1;
    ifdec_flush  = 1'b0;
    decex_bubble = 1'b0;
    if (!reset) begin
      if (ex_br_taken) begin
        hz_d = HZ_FLUSH;
      end else if (hazard) begin
        hz_d = HZ_STALL;
      end
    end
    case (hz_d)
      HZ_FLUSH: begin
        ifdec_flush  = 1'b1;
        decex_bubble = 1'b1;
      end
      HZ_STALL: begin
        pc_we        = 1'b0;
        ifdec_we     = 1'b0;
        decex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered decision; a FLUSH here marks the next DEC instruction invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hz_q <= HZ_RUN;
    end else begin
      hz_q <= hz_d;
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((hz_d == HZ_STALL) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNTW'(1);
      end
      if ((hz_d == HZ_FLUSH) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNTW'(1);
      end
    end
  end

  hazard_shadow_stage u_ex (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (decex_bubble),
    .src    (dec_e),
    .entry  (ex_e)
  );

  hazard_shadow_stage u_me (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (1'b0),
    .src    (ex_e),
    .entry  (me_e)
  );

  hazard_shadow_stage u_wb (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (1'b0),
    .src    (me_e),
    .entry  (wb_e)
  );

  assign ex_valid = ex_e.valid;
  assign me_valid = me_e.valid;
  assign wb_valid = wb_e.valid;
  assign hz_state = hz_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a small expectation queue.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dec_op, dec_rs1, dec_rs2, dec_rd;
  logic        ex_br_taken;
  logic        pc_we, ifdec_we, ifdec_flush, decex_bubble;
  logic        ex_valid, me_valid, wb_valid;
  logic [1:0]  hz_state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_we, s_ifdec_we, s_ifdec_flush, s_decex_bubble;
  logic        s_ex_valid, s_me_valid, s_wb_valid;
  logic [1:0]  s_hz_state;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  logic [3:0] ctl, s_ctl;
  logic [2:0] vld;
  assign ctl   = {pc_we, ifdec_we, ifdec_flush, decex_bubble};
  assign s_ctl = {s_pc_we, s_ifdec_we, s_ifdec_flush, s_decex_bubble};
  assign vld   = {ex_valid, me_valid, wb_valid};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.OPW(4), .RW(4), .CNTW(16)) u_dut (
    .clk(clk), .reset(reset), .dec_op(dec_op), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .ex_br_taken(ex_br_taken), .pc_we(pc_we), .ifdec_we(ifdec_we),
    .ifdec_flush(ifdec_flush), .decex_bubble(decex_bubble), .ex_valid(ex_valid),
    .me_valid(me_valid), .wb_valid(wb_valid), .hz_state(hz_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance so saturation is reached in a short run.
  pipeline_hazard_ctrl #(.OPW(4), .RW(4), .CNTW(4)) u_sat (
    .clk(clk), .reset(reset), .dec_op(dec_op), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .ex_br_taken(ex_br_taken), .pc_we(s_pc_we), .ifdec_we(s_ifdec_we),
    .ifdec_flush(s_ifdec_flush), .decex_bubble(s_decex_bubble), .ex_valid(s_ex_valid),
    .me_valid(s_me_valid), .wb_valid(s_wb_valid), .hz_state(s_hz_state),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    string      tag;
    logic [3:0] ctl;
    logic [2:0] v;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_stall, exp_flush;
  logic [3:0]  exp_stall_s, exp_flush_s;
  logic [1:0]  exp_hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_stall   = '0;
    exp_flush   = '0;
    exp_stall_s = '0;
    exp_flush_s = '0;
    exp_hz      = 2'b00;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    chk({tag, ".sat_stall_cnt"}, 32'(s_stall_cnt), 32'(exp_stall_s));
    chk({tag, ".sat_flush_cnt"}, 32'(s_flush_cnt), 32'(exp_flush_s));
  endtask

  // One pipeline cycle: drive DEC, queue the expectation, check mid-cycle,
  // then check the counters after the edge. Entered and left at posedge+1.
  task automatic cyc(input string tag, input logic [3:0] op, input logic [3:0] rs1,
                     input logic [3:0] rs2, input logic [3:0] rd, input logic br,
                     input logic [3:0] ectl, input logic [2:0] ev);
    exp_t e;
    dec_op = op; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; ex_br_taken = br;
    e.tag = tag; e.ctl = ectl; e.v = ev;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".ctl"}, 32'(ctl), 32'(e.ctl));
    chk({e.tag, ".sat_ctl"}, 32'(s_ctl), 32'(e.ctl));
    chk({e.tag, ".valids"}, 32'(vld), 32'(e.v));
    chk({e.tag, ".hz_state"}, 32'(hz_state), 32'(exp_hz));
    exp_hz = (e.ctl == C_STALL) ? 2'b01 : (e.ctl == C_FLUSH) ? 2'b10 : 2'b00;
    if (e.ctl == C_STALL) begin
      if (exp_stall != 16'hFFFF) exp_stall++;
      if (exp_stall_s != 4'hF) exp_stall_s++;
    end
    if (e.ctl == C_FLUSH) begin
      if (exp_flush != 16'hFFFF) exp_flush++;
      if (exp_flush_s != 4'hF) exp_flush_s++;
    end
    @(posedge clk);
    #1;
    chk_cnt(e.tag);
  endtask

  task automatic nop(input string tag, input logic [2:0] ev);
    cyc(tag, ALUI, 4'd0, 4'd0, 4'd0, 1'b0, C_RUN, ev);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset with a taken branch and a hazard-looking DEC: outputs stay RUN.
    reset = 1'b1; ex_br_taken = 1'b1;
    dec_op = ALUR; dec_rs1 = 4'd1; dec_rs2 = 4'd2; dec_rd = 4'd3;
    @(negedge clk);
    chk("rst.ctl", 32'(ctl), 32'(C_RUN));
    chk("rst.valids", 32'(vld), 32'(3'b000));
    chk("rst.hz_state", 32'(hz_state), 32'(2'b00));
    chk_cnt("rst");
    dec_op = ALUI; dec_rs1 = 4'd0; dec_rs2 = 4'd0; dec_rd = 4'd0; ex_br_taken = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Load-use: 3 stalls.
    cyc("a1_lw",    LWOP, 4'd1, 4'd0, 4'd3, 1'b0, C_RUN,   3'b100);
    cyc("a2_use",   ALUR, 4'd3, 4'd1, 4'd4, 1'b0, C_STALL, 3'b110);
    cyc("a3_use",   ALUR, 4'd3, 4'd1, 4'd4, 1'b0, C_STALL, 3'b011);
    cyc("a4_use",   ALUR, 4'd3, 4'd1, 4'd4, 1'b0, C_STALL, 3'b001);
    cyc("a5_use",   ALUR, 4'd3, 4'd1, 4'd4, 1'b0, C_RUN,   3'b000);
    nop("a6_nop", 3'b100);
    nop("a7_nop", 3'b110);
    nop("a8_nop", 3'b111);

    // Producer two ahead, read through rs2 of SW: 2 stalls.
    cyc("b1_alur",  ALUR, 4'd0, 4'd0, 4'd5, 1'b0, C_RUN,   3'b111);
    nop("b2_nop", 3'b111);
    cyc("b3_sw",    SWOP, 4'd0, 4'd5, 4'd0, 1'b0, C_STALL, 3'b111);
    cyc("b4_sw",    SWOP, 4'd0, 4'd5, 4'd0, 1'b0, C_STALL, 3'b011);
    cyc("b5_sw",    SWOP, 4'd0, 4'd5, 4'd0, 1'b0, C_RUN,   3'b001);

    // Taken branch over a hazard: FLUSH, next DEC invalid.
    cyc("c1_lw",    LWOP, 4'd0, 4'd0, 4'd6, 1'b0, C_RUN,   3'b100);
    cyc("c2_flush", ALUR, 4'd6, 4'd0, 4'd7, 1'b1, C_FLUSH, 3'b110);
    cyc("c3_inval", ALUR, 4'd6, 4'd6, 4'd8, 1'b0, C_RUN,   3'b011);
    nop("c4_nop", 3'b001);
    nop("c5_nop", 3'b100);
    nop("c6_nop", 3'b110);

    // r0 never creates a dependence.
    cyc("d1_alui0", ALUI, 4'd0, 4'd0, 4'd0, 1'b0, C_RUN,   3'b111);
    cyc("d2_rd_r0", ALUR, 4'd0, 4'd0, 4'd9, 1'b0, C_RUN,   3'b111);
    cyc("d3_lw0",   LWOP, 4'd0, 4'd0, 4'd0, 1'b0, C_RUN,   3'b111);
    cyc("d4_sw_r0", SWOP, 4'd0, 4'd0, 4'd0, 1'b0, C_RUN,   3'b111);

    // Source-usage and writes-register decode.
    cyc("e1_lw",    LWOP,   4'd0,  4'd0,  4'd10, 1'b0, C_RUN,   3'b111);
    cyc("e2_alui",  ALUI,   4'd0,  4'd10, 4'd11, 1'b0, C_RUN,   3'b111);
    cyc("e3_br",    BRANCH, 4'd0,  4'd10, 4'd13, 1'b0, C_STALL, 3'b111);
    cyc("e4_br",    BRANCH, 4'd0,  4'd10, 4'd13, 1'b0, C_STALL, 3'b011);
    cyc("e5_br",    BRANCH, 4'd0,  4'd10, 4'd13, 1'b0, C_RUN,   3'b001);
    cyc("e6_rd13",  ALUR,   4'd13, 4'd0,  4'd12, 1'b0, C_RUN,   3'b100);
    cyc("e7_cmpi",  CMPI,   4'd12, 4'd0,  4'd14, 1'b0, C_STALL, 3'b110);
    cyc("e8_cmpi",  CMPI,   4'd12, 4'd0,  4'd14, 1'b0, C_STALL, 3'b011);
    cyc("e9_cmpi",  CMPI,   4'd12, 4'd0,  4'd14, 1'b0, C_STALL, 3'b001);
    cyc("e10_cmpi", CMPI,   4'd12, 4'd0,  4'd14, 1'b0, C_RUN,   3'b000);

    // Reset pulsed during the second stall cycle.
    cyc("f1_lw",    LWOP, 4'd0, 4'd0, 4'd7, 1'b0, C_RUN,   3'b100);
    cyc("f2_use",   ALUR, 4'd7, 4'd0, 4'd8, 1'b0, C_STALL, 3'b110);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("f3_async.valids", 32'(vld), 32'(3'b000));
    chk("f3_async.hz_state", 32'(hz_state), 32'(2'b00));
    chk("f3_async.ctl", 32'(ctl), 32'(C_RUN));
    chk_cnt("f3_async");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("f4_release.ctl", 32'(ctl), 32'(C_RUN));
    chk("f4_release.valids", 32'(vld), 32'(3'b000));
    @(posedge clk);
    #1;
    chk("f4_edge.hz_state", 32'(hz_state), 32'(2'b00));
    chk_cnt("f4_edge");
    nop("f5_nop", 3'b100);

    // Dependence chain: 3 stalls per link; the 4-bit instance saturates at 15.
    cyc("g0_lw", LWOP, 4'd0, 4'd0, 4'd1, 1'b0, C_RUN, 3'b110);
    cyc("g1_s1", ALUR, 4'd1, 4'd0, 4'd2, 1'b0, C_STALL, 3'b111);
    cyc("g1_s2", ALUR, 4'd1, 4'd0, 4'd2, 1'b0, C_STALL, 3'b011);
    cyc("g1_s3", ALUR, 4'd1, 4'd0, 4'd2, 1'b0, C_STALL, 3'b001);
    cyc("g1_r",  ALUR, 4'd1, 4'd0, 4'd2, 1'b0, C_RUN,   3'b000);
    for (int k = 2; k <= 6; k++) begin
      cyc($sformatf("g%0d_s1", k), ALUR, 4'(k), 4'd0, 4'(k + 1), 1'b0, C_STALL, 3'b100);
      cyc($sformatf("g%0d_s2", k), ALUR, 4'(k), 4'd0, 4'(k + 1), 1'b0, C_STALL, 3'b010);
      cyc($sformatf("g%0d_s3", k), ALUR, 4'(k), 4'd0, 4'(k + 1), 1'b0, C_STALL, 3'b001);
      cyc($sformatf("g%0d_r", k),  ALUR, 4'(k), 4'd0, 4'(k + 1), 1'b0, C_RUN,   3'b000);
    end
    chk("g_end.sat_stall_cnt", 32'(s_stall_cnt), 32'(4'hF));
    chk("g_end.stall_cnt", 32'(stall_cnt), 32'(16'd18));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk rises, reset acts without waiting for clk.
REQ-002 Parameter OPW, default 4, SHALL set the width of the opcode fields.
REQ-003 Parameter RW, default 4, SHALL set the width of the register-index fields.
REQ-004 Parameter CNTW, default 16, SHALL set the width of the statistics counters.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 dec_op  in  OPW  opcode of the instruction in DEC.
REQ-008 dec_rs1, dec_rs2, dec_rd  in  RW  DEC source and destination indices.
REQ-009 ex_br_taken  in  1  branch or JAL resolved taken in EX this cycle.
REQ-010 pc_we  out  1  PC update enable.
REQ-011 ifdec_we  out  1  IF/DEC register load enable.
REQ-012 ifdec_flush  out  1  clear IF/DEC to a bubble.
REQ-013 decex_bubble  out  1  load a bubble into DEC/EX.
REQ-014 ex_valid, me_valid, wb_valid  out  1  EX, ME and WB stages hold a real instruction; used to gate aluOp, wrMem and wrReg.
REQ-015 hz_state  out  2  registered decision of the previous cycle: 00 RUN, 01 STALL, 10 FLUSH.
REQ-016 stall_cnt, flush_cnt  out  CNTW  saturating event counters.

Function
REQ-017 Writes-register SHALL be true for every opcode except SWOP (0011) and BRANCH (0010).
REQ-018 rs1 SHALL be read by ALUR, ALUI, LWOP, SWOP, CMPR, CMPI, BRANCH and JAL.
REQ-019 rs2 SHALL be read only by ALUR, CMPR, SWOP and BRANCH.
REQ-020 The block SHALL hold shadow {valid, wr, rd} entries for EX, ME and WB.
REQ-021 Each clock edge SHALL shift the entries DEC->EX->ME->WB, discarding the old WB entry.
REQ-022 DEC->EX SHALL shift in an invalid entry when decex_bubble=1.
REQ-023 The DEC instruction SHALL be treated as valid unless the previous cycle asserted ifdec_flush.
REQ-024 Hazard SHALL be true when the DEC instruction is valid and a used source equals rd of any valid EX, ME or WB entry with wr=1.
REQ-025 The register file has no write-through and there is no forwarding, so the WB stage SHALL count in REQ-024.
REQ-026 A hazard SHALL NOT be raised for register index 0.
REQ-027 If ex_br_taken=1 (FLUSH, highest priority), outputs SHALL be pc_we=1, ifdec_we=1, ifdec_flush=1, decex_bubble=1.
REQ-028 If ex_br_taken=0 and hazard=1 (STALL), outputs SHALL be pc_we=0, ifdec_we=0, ifdec_flush=0, decex_bubble=1.
REQ-029 Otherwise (RUN), outputs SHALL be pc_we=1, ifdec_we=1, ifdec_flush=0, decex_bubble=0.
REQ-030 Control outputs SHALL be combinational within the cycle, with zero-cycle latency from the inputs and the shadow state.
REQ-031 When taken and hazard are both true, FLUSH SHALL win and the stall SHALL NOT be counted, because the stalled instruction is squashed.
REQ-032 hz_state SHALL register the current decision at each edge.
REQ-033 stall_cnt SHALL increment once per STALL cycle and flush_cnt once per FLUSH cycle.
REQ-034 Both counters SHALL saturate at all-ones and never wrap.
REQ-035 A load-use dependence SHALL stall exactly 3 cycles, one each while the producer is in EX, ME and WB.
REQ-036 A dependence on a producer one instruction further ahead SHALL stall 2 cycles, and on one two further ahead 1 cycle.

Reset
REQ-037 While reset=1, all shadow valid bits SHALL be 0, hz_state SHALL be RUN, and stall_cnt and flush_cnt SHALL be 0.
REQ-038 While reset=1, outputs SHALL be pc_we=1, ifdec_we=1, ifdec_flush=0, decex_bubble=0, and ex_valid=me_valid=wb_valid=0.
REQ-039 Reset asserted mid-STALL or mid-FLUSH SHALL take effect immediately, with no pending squash or stall surviving reset.
REQ-040 The first edge after reset release SHALL operate as RUN with empty stages.

Structure
REQ-041 Opcode constants (ALUR, ALUI, LWOP, SWOP, CMPR, CMPI, BRANCH, JAL) SHALL live in a shared package pipeline_pkg, with the hz_state encoding and the shadow-entry record type.
REQ-042 Stage control decoding SHALL remain in PipelineController, which is unchanged; this block only gates it through the *_valid outputs.
REQ-043 One sub-module, hazard_shadow_stage (a single {valid, wr, rd} register with load and bubble inputs), SHALL be instantiated three times.

Verification
REQ-044 Scenario: LW r3 then ALUR r4=r3+r1 -> 3 STALL cycles (pc_we=0), stall_cnt=3, then RUN.
REQ-045 Scenario: ALUR r5, an independent instruction, then SW reading r5 as rs2 -> 2 STALL cycles.
REQ-046 Scenario: BRANCH taken (ex_br_taken=1) while DEC has a hazard -> FLUSH for 1 cycle, stall_cnt unchanged, flush_cnt=1, next DEC instruction invalid and no hazard raised.
REQ-047 Scenario: ALUI r0 followed by a reader of r0 -> no stall.
REQ-048 Scenario: stall_cnt preloaded via 65535 STALL cycles, then one more -> stays 0xFFFF.
REQ-049 Scenario: reset pulsed during the 2nd STALL cycle -> all valids 0, hz_state=00 asynchronously, and RUN on release.
